biphase_mark_decode: RTL and testbench

// - S/PDIF (IEC 60958) subframe decoder. Consumes one biphase-mark cell (half-bit) per valid clock.
// - Locks onto preambles and decodes time slots 4..31 into a serial bit stream.
// - Tags each bit with channel and frame index (0..191) within the 192-frame block.
// - Sits between the cell-recovery front end and the audio sample deserializer.

---
 rtl/biphase_mark_pkg.sv | 28 ++
 rtl/biphase_mark_decode_if.sv | 37 +++
 rtl/bmc_preamble_match.sv | 19 +
 rtl/biphase_mark_decode.sv | 130 +++++++++++++
 tb/tb_biphase_mark_decode.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/biphase_mark_pkg.sv
// Shared definitions for the biphase-mark (S/PDIF) subframe decoder.
// - Preamble codes in first-cell-first order (oldest cell in the MSB).
// - Decoder state encoding.
// - Default block and subframe geometry.
// - A polarity-insensitive code compare helper.
package biphase_mark_pkg;

    localparam int unsigned DEFAULT_FRAMES_PER_BLOCK = 192;
    localparam int unsigned DEFAULT_SUBFRAME_CELLS   = 64;
    localparam int unsigned PREAMBLE_CELLS           = 8;
    localparam int unsigned FRAME_CNT_W              = 8;

    localparam logic [7:0] PREAMBLE_Z = 8'hE8;
    localparam logic [7:0] PREAMBLE_X = 8'hE2;
    localparam logic [7:0] PREAMBLE_Y = 8'hE4;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PRE
    } state_e;

    // The line polarity is unknown, so a preamble also matches in its inverted form.
    function automatic logic code_match(input logic [7:0] window, input logic [7:0] code);
        return (window == code) || (window == ~code);
    endfunction

endpackage

// File: rtl/biphase_mark_decode_if.sv
// Cell-in / bit-out bundle of the biphase-mark decoder.
//   vin            cell valid; a cell is consumed only while vin=1
//   din            biphase-mark cell level
//   dout           decoded bit, meaningful while vout=1
//   vout           one-cycle strobe per decoded bit
//   frame_counter  frame index 0..191 inside the channel-status block
//   channel        0 = channel A (Z/X preamble), 1 = channel B (Y preamble)
// master: the side that supplies cells and collects bits; slave: the decoder.
interface biphase_mark_decode_if;
    import biphase_mark_pkg::*;

    logic                   vin;
    logic                   din;
    logic                   dout;
    logic                   vout;
    logic [FRAME_CNT_W-1:0] frame_counter;
    logic                   channel;

    modport master (
        output vin,
        output din,
        input  dout,
        input  vout,
        input  frame_counter,
        input  channel
    );

    modport slave (
        input  vin,
        input  din,
        output dout,
        output vout,
        output frame_counter,
        output channel
    );

endinterface

// File: rtl/bmc_preamble_match.sv
// Combinational preamble classifier for an 8-cell window.
//   window  8 cells, oldest in the MSB
//   is_z    window is the Z (block start) preamble, either polarity
//   is_x    window is the X (channel A) preamble, either polarity
//   is_y    window is the Y (channel B) preamble, either polarity
module bmc_preamble_match
    import biphase_mark_pkg::*;
(
    input  logic [7:0] window,
    output logic       is_z,
    output logic       is_x,
    output logic       is_y
);

    assign is_z = code_match(window, PREAMBLE_Z);
    assign is_x = code_match(window, PREAMBLE_X);
    assign is_y = code_match(window, PREAMBLE_Y);

endmodule

// File: rtl/biphase_mark_decode.sv
// S/PDIF subframe decoder. Takes one biphase-mark cell per valid clock, locks on a Z
// preamble, decodes time slots 4..31 into a serial bit stream and tags every bit with
// its channel and frame index inside the 192-frame block.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   biphase_mark_decode_if slave: vin/din in, dout/vout/frame_counter/channel out
module biphase_mark_decode
    import biphase_mark_pkg::*;
#(
    parameter int unsigned FRAMES_PER_BLOCK = DEFAULT_FRAMES_PER_BLOCK,
    parameter int unsigned SUBFRAME_CELLS   = DEFAULT_SUBFRAME_CELLS
) (
    input logic                  clk,
    input logic                  rst,
    biphase_mark_decode_if.slave bus
);

    localparam int unsigned CntW = $clog2(SUBFRAME_CELLS);

    localparam logic [CntW-1:0] CntFirstData = CntW'(PREAMBLE_CELLS);
    localparam logic [CntW-1:0] CntLastPre   = CntW'(PREAMBLE_CELLS - 1);
    localparam logic [CntW-1:0] CntLastData  = CntW'(SUBFRAME_CELLS - 1);

    localparam logic [FRAME_CNT_W-1:0] FrameLast = FRAME_CNT_W'(FRAMES_PER_BLOCK - 1);

    state_e                    state_q;
    logic [CntW-1:0]           cell_cnt_q;
    logic [PREAMBLE_CELLS-1:0] shreg_q;
    logic                      dout_q;
    logic                      vout_q;
    logic [FRAME_CNT_W-1:0]    frame_q;
    logic                      channel_q;

    logic [PREAMBLE_CELLS-1:0] window;
    logic                      is_z;
    logic                      is_x;
    logic                      is_y;
    logic                      cell_edge;

    // Window including the cell being consumed, so a preamble is recognised on its last cell.
    assign window = {shreg_q[PREAMBLE_CELLS-2:0], bus.din};

    // Level change against the previous cell. On the first cell of a pair this is the
    // mandatory boundary transition; on the second cell it is the decoded bit value.
    assign cell_edge = bus.din ^ shreg_q[0];

    bmc_preamble_match u_preamble_match (
        .window (window),
        .is_z   (is_z),
        .is_x   (is_x),
        .is_y   (is_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            cell_cnt_q <= '0;
            shreg_q    <= '0;
            dout_q     <= 1'b0;
            vout_q     <= 1'b0;
            frame_q    <= '0;
            channel_q  <= 1'b0;
        end else begin
            vout_q <= 1'b0;
            if (bus.vin) begin
                shreg_q <= window;
                unique case (state_q)
                    HUNT: begin
                        // Only a block start may lock, so frame_counter is known.
                        if (is_z) begin
                            state_q    <= DATA;
                            cell_cnt_q <= CntFirstData;
                            frame_q    <= '0;
                            channel_q  <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (!cell_cnt_q[0]) begin
                            if (cell_edge) begin
                                cell_cnt_q <= cell_cnt_q + 1'b1;
                            end else begin
                                state_q    <= HUNT;
                                cell_cnt_q <= '0;
                            end
                        end else begin
                            dout_q <= cell_edge;
                            vout_q <= 1'b1;
                            if (cell_cnt_q == CntLastData) begin
                                state_q    <= PRE;
                                cell_cnt_q <= '0;
                            end else begin
                                cell_cnt_q <= cell_cnt_q + 1'b1;
                            end
                        end
                    end
                    PRE: begin
                        if (cell_cnt_q != CntLastPre) begin
                            cell_cnt_q <= cell_cnt_q + 1'b1;
                        end else if (is_z || is_x || is_y) begin
                            state_q    <= DATA;
                            cell_cnt_q <= CntFirstData;
                            if (is_z) begin
                                frame_q   <= '0;
                                channel_q <= 1'b0;
                            end else if (is_x) begin
                                frame_q   <= (frame_q == FrameLast) ? '0 : frame_q + 1'b1;
                                channel_q <= 1'b0;
                            end else begin
                                channel_q <= 1'b1;
                            end
                        end else begin
                            state_q    <= HUNT;
                            cell_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= HUNT;
                        cell_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.dout          = dout_q;
    assign bus.vout          = vout_q;
    assign bus.frame_counter = frame_q;
    assign bus.channel       = channel_q;

endmodule

// File: tb/tb_biphase_mark_decode.sv
// Self-checking bench for biphase_mark_decode. Stimulus is biphase-mark encoded in the
// bench (random payloads, random vin gaps) and the expected strobe list is computed from
// the whole consumed cell stream by slot position arithmetic.
module tb_biphase_mark_decode;

    typedef struct packed {
        bit       d;
        bit [7:0] fc;
        bit       ch;
    } tag_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    biphase_mark_decode_if bus ();

    biphase_mark_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   gap_pct = 0;
    bit   level = 1'b0;
    bit   tx_q[$];
    bit   stream_q[$];
    bit   pad_q[$];
    tag_t got_q[$];
    tag_t exp_q[$];

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.vout === 1'b1) begin
            got_q.push_back({bus.dout, bus.frame_counter, bus.channel});
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic cycle(input bit v, input bit d);
        bus.vin = v;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cells(input int n);
        bit c;
        for (int k = 0; k < n && tx_q.size() > 0; k++) begin
            while ($urandom_range(99) < gap_pct) cycle(1'b0, 1'($urandom_range(1)));
            c = tx_q.pop_front();
            cycle(1'b1, c);
            stream_q.push_back(c);
        end
    endtask

    task automatic flush();
        drive_cells(tx_q.size());
        cycle(1'b0, 1'b1);
    endtask

    task automatic push_raw(input bit [63:0] v);
        for (int k = 63; k >= 0; k--) tx_q.push_back(v[k]);
        level = v[0];
    endtask

    // Real biphase-mark: every cell pair starts with a transition, a 1 adds a mid-bit one.
    task automatic enc_subframe(input bit [7:0] pre, input bit [27:0] data);
        bit [7:0] p;
        bit       c0;
        bit       c1;
        p = level ? ~pre : pre;
        for (int k = 7; k >= 0; k--) tx_q.push_back(p[k]);
        level = p[0];
        for (int s = 0; s < 28; s++) begin
            c0 = ~level;
            c1 = data[s] ? ~c0 : c0;
            tx_q.push_back(c0);
            tx_q.push_back(c1);
            level = c1;
        end
    endtask

    task automatic enc_block();
        bit [7:0] pre;
        for (int f = 0; f < 384; f++) begin
            pre = (f == 0) ? 8'hE8 : ((f % 2 == 1) ? 8'hE4 : 8'hE2);
            enc_subframe(pre, 28'($urandom()));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.vin = 1'b0;
        bus.din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        stream_q.delete();
        got_q.delete();
        level = 1'b0;
    endtask

    // ---------------------------------------------------------------- reference model
    function automatic bit [7:0] window_at(input int e);
        bit [7:0] w;
        for (int k = 0; k < 8; k++) w[7 - k] = pad_q[e - 7 + k];
        return w;
    endfunction

    function automatic bit is_code(input bit [7:0] w, input bit [7:0] code);
        return (w == code) || (w == ~code);
    endfunction

    // Walk the consumed cells: find a Z, then read slots 4..31 at fixed offsets from the
    // subframe start and classify the preamble 64 cells later.
    function automatic void build_expected();
        int       n;
        int       i;
        int       a;
        int       base;
        int       fc;
        bit       ch;
        bit       hunting;
        bit       stop;
        bit [7:0] w;
        tag_t     t;
        pad_q.delete();
        for (int k = 0; k < 8; k++) pad_q.push_back(1'b0);
        foreach (stream_q[k]) pad_q.push_back(stream_q[k]);
        n = pad_q.size();
        exp_q.delete();
        hunting = 1'b1;
        stop = 1'b0;
        i = 8;
        base = 0;
        fc = 0;
        ch = 1'b0;
        while (!stop) begin
            if (hunting) begin
                if (i >= n) begin
                    stop = 1'b1;
                end else if (is_code(window_at(i), 8'hE8)) begin
                    hunting = 1'b0;
                    base = i - 7;
                    fc = 0;
                    ch = 1'b0;
                end else begin
                    i++;
                end
            end else begin
                for (int s = 4; s < 32 && !hunting && !stop; s++) begin
                    a = base + 2 * s;
                    if (a + 1 >= n) begin
                        stop = 1'b1;
                    end else if (pad_q[a] == pad_q[a - 1]) begin
                        hunting = 1'b1;
                        i = a + 1;
                    end else begin
                        t.d = pad_q[a] ^ pad_q[a + 1];
                        t.fc = 8'(fc);
                        t.ch = ch;
                        exp_q.push_back(t);
                    end
                end
                if (!hunting && !stop) begin
                    if (base + 71 >= n) begin
                        stop = 1'b1;
                    end else begin
                        w = window_at(base + 71);
                        if (is_code(w, 8'hE8)) begin
                            fc = 0;
                            ch = 1'b0;
                        end else if (is_code(w, 8'hE2)) begin
                            fc = (fc + 1) % 192;
                            ch = 1'b0;
                        end else if (is_code(w, 8'hE4)) begin
                            ch = 1'b1;
                        end else begin
                            hunting = 1'b1;
                            i = base + 72;
                        end
                        base += 64;
                    end
                end
            end
        end
    endfunction

    function automatic int first_diff();
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            if (got_q[k] !== exp_q[k]) return k;
        end
        return -1;
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        bus.vin = 1'b0;
        bus.din = 1'b0;
        #3;
        total++;
        if (bus.dout !== 1'b0) begin
            bad++; $display("FAIL reset_dout got=%b want=0", bus.dout);
        end
        total++;
        if (bus.vout !== 1'b0) begin
            bad++; $display("FAIL reset_vout got=%b want=0", bus.vout);
        end
        total++;
        if (bus.frame_counter !== 8'd0) begin
            bad++; $display("FAIL reset_frame got=%0d want=0", bus.frame_counter);
        end
        total++;
        if (bus.channel !== 1'b0) begin
            bad++; $display("FAIL reset_channel got=%b want=0", bus.channel);
        end
        do_reset();
    endtask

    task automatic test_all_ones();
        int idx;
        do_reset();
        gap_pct = 15;
        push_raw(64'hE8FF_FFFF_FFFF_FFFF);
        flush();
        repeat (4) cycle(1'b0, 1'b1);
        build_expected();
        // Cells 8/9 (1,1) follow a 0 cell, a legal boundary carrying a 0 bit;
        // cell 10 repeats cell 9 and drops lock, so nothing else may appear.
        total++;
        if (got_q.size() !== 1) begin
            bad++; $display("FAIL ones_count got=%0d want=1", got_q.size());
        end
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL ones_model_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        idx = first_diff();
        total++;
        if (idx != -1) begin
            bad++;
            $display("FAIL ones_tag idx=%0d got=%h want=%h", idx, got_q[idx], exp_q[idx]);
        end
    endtask

    task automatic test_single_subframe();
        int   idx;
        tag_t e;
        do_reset();
        gap_pct = 15;
        push_raw(64'hE8CC_AAAA_AAAA_AACC);
        flush();
        total++;
        if (got_q.size() !== 28) begin
            bad++; $display("FAIL single_count got=%0d want=28", got_q.size());
        end
        idx = -1;
        for (int k = 0; k < got_q.size(); k++) begin
            e.d = (k >= 4 && k < 24);
            e.fc = 8'd0;
            e.ch = 1'b0;
            if (got_q[k] !== e && idx == -1) idx = k;
        end
        total++;
        if (idx != -1) begin
            bad++; $display("FAIL single_bits idx=%0d got=%h", idx, got_q[idx]);
        end
        build_expected();
        idx = first_diff();
        total++;
        if (idx != -1 || got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL single_model idx=%0d got_n=%0d want_n=%0d", idx, got_q.size(),
                     exp_q.size());
        end
    endtask

    task automatic test_violation();
        int idx;
        do_reset();
        gap_pct = 10;
        enc_subframe(8'hE8, 28'($urandom()));
        enc_subframe(8'hE4, 28'($urandom()));
        // First cell of slot pair 10 of the Y subframe repeats the cell before it.
        tx_q[92] = tx_q[91];
        enc_subframe(8'hE2, 28'($urandom()));
        enc_subframe(8'hE4, 28'($urandom()));
        enc_subframe(8'hE8, 28'($urandom()));
        enc_subframe(8'hE4, 28'($urandom()));
        flush();
        // 28 (Z) + 10 before the break + 0 + 0 while hunting + 28 (Z) + 28 (Y)
        total++;
        if (got_q.size() !== 94) begin
            bad++; $display("FAIL viol_count got=%0d want=94", got_q.size());
        end
        if (got_q.size() > 66) begin
            total++;
            if (got_q[37].ch !== 1'b1 || got_q[38].ch !== 1'b0 || got_q[38].fc !== 8'd0) begin
                bad++;
                $display("FAIL viol_relock got=%h/%h want ch1 then fc0 ch0", got_q[37], got_q[38]);
            end
            total++;
            if (got_q[66].ch !== 1'b1 || got_q[66].fc !== 8'd0) begin
                bad++; $display("FAIL viol_y got=%h want fc0 ch1", got_q[66]);
            end
        end
        build_expected();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL viol_model_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        idx = first_diff();
        total++;
        if (idx != -1) begin
            bad++;
            $display("FAIL viol_tag idx=%0d got=%h want=%h", idx, got_q[idx], exp_q[idx]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        gap_pct = 10;
        enc_subframe(8'hE8, 28'($urandom()));
        enc_subframe(8'hE4, 28'($urandom()));
        drive_cells(64 + 30);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.vout !== 1'b0 || bus.dout !== 1'b0 || bus.frame_counter !== 8'd0 ||
            bus.channel !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async got=%b%b/%0d/%b want=00/0/0", bus.vout, bus.dout,
                     bus.frame_counter, bus.channel);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tx_q.delete();
        stream_q.delete();
        got_q.delete();
        enc_subframe(8'hE2, 28'($urandom()));
        enc_subframe(8'hE4, 28'($urandom()));
        flush();
        total++;
        if (got_q.size() !== 0) begin
            bad++; $display("FAIL midrst_nolock got=%0d want=0", got_q.size());
        end
        enc_subframe(8'hE8, 28'($urandom()));
        flush();
        total++;
        if (got_q.size() !== 28) begin
            bad++; $display("FAIL midrst_relock got=%0d want=28", got_q.size());
        end
    endtask

    task automatic test_blocks_gap();
        int       idx;
        bit       hold_d;
        bit [7:0] hold_fc;
        bit       hold_ch;
        bit       vout_seen;
        bit       moved;
        do_reset();
        gap_pct = 0;
        enc_block();
        enc_block();
        flush();
        hold_d = bus.dout;
        hold_fc = bus.frame_counter;
        hold_ch = bus.channel;
        total++;
        if (hold_fc !== 8'd191 || hold_ch !== 1'b1) begin
            bad++; $display("FAIL blk_end got=%0d/%b want=191/1", hold_fc, hold_ch);
        end
        vout_seen = 1'b0;
        moved = 1'b0;
        repeat (384) begin
            cycle(1'b0, 1'b1);
            if (bus.vout !== 1'b0) vout_seen = 1'b1;
            if (bus.dout !== hold_d || bus.frame_counter !== hold_fc || bus.channel !== hold_ch)
                moved = 1'b1;
        end
        total++;
        if (vout_seen) begin
            bad++; $display("FAIL gap_vout got=1 want=0");
        end
        total++;
        if (moved) begin
            bad++; $display("FAIL gap_hold got=changed want=held");
        end
        enc_block();
        // One extra X after the last Y of a block wraps 191 -> 0.
        enc_subframe(8'hE2, 28'($urandom()));
        flush();
        total++;
        if (got_q.size() !== 3 * 384 * 28 + 28) begin
            bad++; $display("FAIL blk_count got=%0d want=%0d", got_q.size(), 3 * 384 * 28 + 28);
        end
        if (got_q.size() > 384 * 28) begin
            total++;
            if (got_q[384 * 28 - 1].fc !== 8'd191 || got_q[384 * 28].fc !== 8'd0 ||
                got_q[384 * 28].ch !== 1'b0) begin
                bad++;
                $display("FAIL blk_boundary got=%h/%h want fc191 then fc0 ch0",
                         got_q[384 * 28 - 1], got_q[384 * 28]);
            end
        end
        if (got_q.size() > 0) begin
            total++;
            if (got_q[got_q.size() - 1].fc !== 8'd0 || got_q[got_q.size() - 1].ch !== 1'b0) begin
                bad++; $display("FAIL blk_wrap got=%h want fc0 ch0", got_q[got_q.size() - 1]);
            end
        end
        build_expected();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL blk_model_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        idx = first_diff();
        total++;
        if (idx != -1) begin
            bad++;
            $display("FAIL blk_tag idx=%0d got=%h want=%h", idx, got_q[idx], exp_q[idx]);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_subframe();
        test_violation();
        test_mid_reset();
        test_blocks_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
